// File: rtl/sr595_tx_pkg.sv
// Shared state encoding and width helper for the 74x595 chain transmitter.
package sr595_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } tx_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sr595_tx_phase.sv
// DIV-cycle phase timer: phase_tick marks the last cycle of each DIV-cycle phase.
module sr595_tx_phase
    import sr595_tx_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic phase_tick
);

    localparam int CW = clog2_w(DIV + 1);

    logic [CW-1:0] cnt_r;
    logic          last_s;

    assign last_s     = (cnt_r == CW'(DIV - 1));
    assign phase_tick = en & last_s;

    // Count cycles within a phase and restart after the tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || phase_tick) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/sr595_chain_tx.sv
// Serial transmitter for a 74x595 chain: shifts a word on SER/SRCLK, then strobes RCLK.
// Optional SR595_TX_CLR_EN inserts a SRCLR_n pulse before each frame.
module sr595_chain_tx
    import sr595_tx_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             SER,
    output logic             SRCLK,
    output logic             RCLK,
    output logic             OE_n,
    output logic             SRCLR_n,
    output logic             DONE
);

    localparam int BW = clog2_w(WIDTH + 1);

    tx_state_t        state_r, state_nxt;
    logic [WIDTH-1:0] sh_r, sh_nxt;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_nxt;
    logic             ser_r, ser_nxt;
    logic             srclk_r, srclk_nxt;
    logic             rclk_r, rclk_nxt;
    logic             ready_r, ready_nxt;
    logic             done_r, done_nxt;
    logic             oe_n_r, oe_n_nxt;
    logic             tick_s;
    logic             accept_s;
    logic [WIDTH-1:0] sh_adv_s;

    // The bit on the wire is always at the head of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    assign accept_s = VALID & ready_r;
    assign sh_adv_s = (MSB_FIRST != 0) ? (sh_r << 1) : (sh_r >> 1);

    sr595_tx_phase #(.DIV(DIV)) u_phase (
        .clk        (CLK),
        .rst_n      (RST_n),
        .clr        (state_r == IDLE),
        .en         (state_r != IDLE),
        .phase_tick (tick_s)
    );

`ifdef SR595_TX_CLR_EN
    logic srclr_n_r, srclr_n_nxt;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_nxt   = state_r;
        sh_nxt      = sh_r;
        bit_cnt_nxt = bit_cnt_r;
        ser_nxt     = ser_r;
        srclk_nxt   = srclk_r;
        rclk_nxt    = rclk_r;
        ready_nxt   = ready_r;
        done_nxt    = 1'b0;
        oe_n_nxt    = oe_n_r;
`ifdef SR595_TX_CLR_EN
        srclr_n_nxt = 1'b1;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    ready_nxt   = 1'b0;
                    sh_nxt      = DATA;
                    bit_cnt_nxt = '0;
`ifdef SR595_TX_CLR_EN
                    state_nxt   = CLEAR;
                    srclr_n_nxt = 1'b0;
                    ser_nxt     = 1'b0;
`else
                    state_nxt   = SHIFT;
                    ser_nxt     = head_bit(DATA);
`endif
                end else begin
                    ready_nxt = 1'b1;
                end
            end
`ifdef SR595_TX_CLR_EN
            CLEAR: begin
                if (tick_s) begin
                    state_nxt = SHIFT;
                    ser_nxt   = head_bit(sh_r);
                end else begin
                    srclr_n_nxt = 1'b0;
                end
            end
`endif
            SHIFT: begin
                if (!tick_s) begin
                    srclk_nxt = srclk_r;
                end else if (!srclk_r) begin
                    srclk_nxt = 1'b1;
                end else if (bit_cnt_r == BW'(WIDTH - 1)) begin
                    // Last bit clocked in: drop SER and start the latch strobe.
                    srclk_nxt = 1'b0;
                    ser_nxt   = 1'b0;
                    rclk_nxt  = 1'b1;
                    state_nxt = LATCH;
                end else begin
                    srclk_nxt   = 1'b0;
                    sh_nxt      = sh_adv_s;
                    ser_nxt     = head_bit(sh_adv_s);
                    bit_cnt_nxt = bit_cnt_r + BW'(1);
                end
            end
            LATCH: begin
                if (tick_s) begin
                    rclk_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    oe_n_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    rclk_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                srclk_nxt = 1'b0;
                rclk_nxt  = 1'b0;
                ser_nxt   = 1'b0;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r   <= IDLE;
            sh_r      <= '0;
            bit_cnt_r <= '0;
            ser_r     <= 1'b0;
            srclk_r   <= 1'b0;
            rclk_r    <= 1'b0;
            ready_r   <= 1'b0;
            done_r    <= 1'b0;
            oe_n_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt;
            sh_r      <= sh_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            ser_r     <= ser_nxt;
            srclk_r   <= srclk_nxt;
            rclk_r    <= rclk_nxt;
            ready_r   <= ready_nxt;
            done_r    <= done_nxt;
            oe_n_r    <= oe_n_nxt;
        end
    end

`ifdef SR595_TX_CLR_EN
    // Shift-register clear strobe register.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            srclr_n_r <= 1'b1;
        end else begin
            srclr_n_r <= srclr_n_nxt;
        end
    end
    assign SRCLR_n = srclr_n_r;
`else
    assign SRCLR_n = 1'b1;
`endif

    assign READY = ready_r;
    assign SER   = ser_r;
    assign SRCLK = srclk_r;
    assign RCLK  = rclk_r;
    assign OE_n  = oe_n_r;
    assign DONE  = done_r;

endmodule
